// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - in-order (pc, instr) queue between fetch and decode with redirect flush
module fetch_buffer #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Handshake flags come from occupancy alone; no full-buffer pass-through.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
        end
    end

    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - queue-model bench for fetch_buffer: directed cases plus random traffic
module tb_fetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] pop_log[$];

    fetch_buffer #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: a plain FIFO of entries, cleared on flush or reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            automatic bit do_pop  = out_ready && (mq.size() > 0);
            automatic bit do_push = in_valid && (mq.size() < DEPTH);
            ent_t e;
            e.pc = in_pc;
            e.instr = in_instr;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
    end

    always @(negedge clk) begin
        automatic int sz = mq.size();
        chk("count", 32'(count), 32'(sz));
        chk("in_ready", 32'(in_ready), 32'(sz != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(sz != 0));
        chk("out_pc", out_pc, (sz != 0) ? mq[0].pc : 32'h0);
        chk("out_instr", out_instr, (sz != 0) ? mq[0].instr : 32'h0);
        if (reset && out_valid && out_ready && !flush) pop_log.push_back(out_pc);
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && count != 0; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drain_empty", 32'(count), 32'h0);
    endtask

    initial begin
        logic [31:0] exp_seq[$];
        logic [31:0] rpc, rins;
        logic        rv, pend;
        int          guard;
        bit          accepted;

        // Reset state while held
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Streaming with decode always ready: each entry visible one edge after push
        drive(1'b1, 32'h00, 32'h11, 1'b1, 1'b0);
        chk("t1_pc0", out_pc, 32'h00);
        chk("t1_in0", out_instr, 32'h11);
        chk("t1_cnt0", 32'(count), 32'h1);
        drive(1'b1, 32'h04, 32'h22, 1'b1, 1'b0);
        chk("t1_pc1", out_pc, 32'h04);
        chk("t1_cnt1", 32'(count), 32'h1);
        drive(1'b1, 32'h08, 32'h33, 1'b1, 1'b0);
        chk("t1_pc2", out_pc, 32'h08);
        chk("t1_in2", out_instr, 32'h33);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("t1_empty", 32'(out_valid), 32'h0);

        // Fill while stalled, then release; the fifth entry waits for space
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0);
        chk("t2_full_cnt", 32'(count), 32'h4);
        chk("t2_full_rdy", 32'(in_ready), 32'h0);
        drive(1'b1, 32'h110, 32'hA4, 1'b0, 1'b0);
        chk("t2_hold_cnt", 32'(count), 32'h4);
        chk("t2_hold_head", out_pc, 32'h100);
        pop_log.delete();
        pend = 1'b1;
        for (int i = 0; i < 12; i++) begin
            accepted = pend && in_ready;
            drive(pend, 32'h110, 32'hA4, 1'b1, 1'b0);
            if (accepted) pend = 1'b0;
        end
        exp_seq = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
        chk("t2_npop", 32'(pop_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < pop_log.size(); i++) chk("t2_order", pop_log[i], exp_seq[i]);

        // Steady push+pop at count 2 across pointer wrap
        drive(1'b1, 32'h300, 32'h1, 1'b0, 1'b0);
        drive(1'b1, 32'h304, 32'h2, 1'b0, 1'b0);
        pop_log.delete();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h308 + 32'(4 * i), 32'h3 + 32'(i), 1'b1, 1'b0);
            chk("t3_cnt", 32'(count), 32'h2);
        end
        chk("t3_npop", 32'(pop_log.size()), 32'd10);
        for (int i = 0; i < pop_log.size(); i++) chk("t3_order", pop_log[i], 32'h300 + 32'(4 * i));
        drain();

        // Flush dominates a simultaneous push and pop
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h500 + 32'(4 * i), 32'h55, 1'b0, 1'b0);
        chk("t4_pre_cnt", 32'(count), 32'h3);
        drive(1'b1, 32'h50C, 32'h56, 1'b1, 1'b1);
        chk("t4_cnt", 32'(count), 32'h0);
        chk("t4_valid", 32'(out_valid), 32'h0);
        chk("t4_instr", out_instr, 32'h0);
        chk("t4_rdy", 32'(in_ready), 32'h1);
        drive(1'b1, 32'h510, 32'h57, 1'b1, 1'b1);
        drive(1'b1, 32'h514, 32'h58, 1'b1, 1'b1);
        chk("t4_hold_cnt", 32'(count), 32'h0);
        drive(1'b1, 32'h200, 32'h99, 1'b0, 1'b0);
        chk("t4_new_pc", out_pc, 32'h200);
        chk("t4_new_cnt", 32'(count), 32'h1);
        drain();

        // Asynchronous reset between edges
        drive(1'b1, 32'h600, 32'h61, 1'b0, 1'b0);
        drive(1'b1, 32'h604, 32'h62, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("t5_pre_cnt", 32'(count), 32'h2);
        #2 reset = 1'b0;
        #1;
        chk("t5_cnt", 32'(count), 32'h0);
        chk("t5_valid", 32'(out_valid), 32'h0);
        chk("t5_rdy", 32'(in_ready), 32'h1);
        chk("t5_pc", out_pc, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b1, 32'h400, 32'h44, 1'b0, 1'b0);
        chk("t5_fresh_pc", out_pc, 32'h400);
        chk("t5_fresh_in", out_instr, 32'h44);
        drain();

        // Random traffic; producer holds its pair until accepted
        pend = 1'b0;
        rpc = '0;
        rins = '0;
        guard = 0;
        for (int i = 0; i < 2000; i++) begin
            logic fl, ordy;
            if (!pend) begin
                rv   = ($urandom_range(0, 9) < 7);
                rpc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                rins = $urandom;
                pend = rv;
            end
            fl   = ($urandom_range(0, 99) < 3);
            ordy = ($urandom_range(0, 9) < 6);
            accepted = pend && in_ready && !fl;
            drive(pend, rpc, rins, ordy, fl);
            if (accepted || fl) pend = 1'b0;
            if (count > 3'd4) guard++;
        end
        chk("rand_cnt_bound", 32'(guard), 32'h0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
